// File: rtl/cond_unit.sv
// Condition-check and flag-register unit: evaluates the instruction condition
// against the stored NZCV flags and gates the write enables with the registered result.
module cond_unit #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000,
    parameter bit         NV_EXECUTES = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags,
    output logic       CondExQ
);

    logic [3:0] flags_reg;
    logic [3:0] flags_next;
    logic       cond_ex_q_reg;
    logic       cond_ex;
    logic [1:0] flag_write;
    logic       n_flag, z_flag, c_flag, v_flag;

    assign {n_flag, z_flag, c_flag, v_flag} = flags_reg;

    // Condition is judged on the stored flags, so a same-cycle flag update
    // only becomes visible to the following instruction.
    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = z_flag;
            4'b0001: cond_ex = ~z_flag;
            4'b0010: cond_ex = c_flag;
            4'b0011: cond_ex = ~c_flag;
            4'b0100: cond_ex = n_flag;
            4'b0101: cond_ex = ~n_flag;
            4'b0110: cond_ex = v_flag;
            4'b0111: cond_ex = ~v_flag;
            4'b1000: cond_ex = c_flag & ~z_flag;
            4'b1001: cond_ex = ~c_flag | z_flag;
            4'b1010: cond_ex = ~(n_flag ^ v_flag);
            4'b1011: cond_ex = n_flag ^ v_flag;
            4'b1100: cond_ex = ~z_flag & ~(n_flag ^ v_flag);
            4'b1101: cond_ex = z_flag | (n_flag ^ v_flag);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = NV_EXECUTES;
        endcase
    end

    assign flag_write = FlagW & {2{cond_ex}};

    // Bit 1 of flag_write owns {N,Z}, bit 0 owns {C,V}; the halves load independently.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_flag_half
            assign flags_next[2*gi +: 2] = flag_write[gi] ? ALUFlags[2*gi +: 2]
                                                          : flags_reg[2*gi +: 2];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_reg     <= RESET_FLAGS;
            cond_ex_q_reg <= 1'b0;
        end else begin
            flags_reg     <= flags_next;
            cond_ex_q_reg <= cond_ex;
        end
    end

    assign Flags    = flags_reg;
    assign CondExQ  = cond_ex_q_reg;
    assign RegWrite = RegW & cond_ex_q_reg;
    assign MemWrite = MemW & cond_ex_q_reg;
    // Sequential PC advance is never conditional; only branch writes are gated.
    assign PCWrite  = NextPC | (PCS & cond_ex_q_reg);

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: reset, flag split, condition fail/pass, hazard and full sweep.
module tb_cond_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, NextPC, RegW, MemW;

    logic       pc_write_a, reg_write_a, mem_write_a, cond_ex_q_a;
    logic [3:0] flags_a;
    logic       pc_write_b, reg_write_b, mem_write_b, cond_ex_q_b;
    logic [3:0] flags_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cond_unit #(.RESET_FLAGS(4'b0000), .NV_EXECUTES(1'b1)) dut_a (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
        .PCWrite(pc_write_a), .RegWrite(reg_write_a), .MemWrite(mem_write_a),
        .Flags(flags_a), .CondExQ(cond_ex_q_a)
    );

    cond_unit #(.RESET_FLAGS(4'b0101), .NV_EXECUTES(1'b0)) dut_b (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
        .PCWrite(pc_write_b), .RegWrite(reg_write_b), .MemWrite(mem_write_b),
        .Flags(flags_b), .CondExQ(cond_ex_q_b)
    );

    // Reference: ARM condition as base predicate on Cond[3:1], inverted by Cond[0].
    function automatic logic model(input logic [3:0] c, input logic [3:0] f, input logic nv);
        logic base;
        case (c[3:1])
            3'd0: base = f[2];
            3'd1: base = f[1];
            3'd2: base = f[3];
            3'd3: base = f[0];
            3'd4: base = f[1] & ~f[2];
            3'd5: base = (f[3] == f[0]);
            3'd6: base = ~f[2] & (f[3] == f[0]);
            default: base = 1'b1;
        endcase
        if (c == 4'b1111) return nv;
        return base ^ c[0];
    endfunction

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_flags(input logic [3:0] f);
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
        step();
        FlagW = 2'b00;
    endtask

    initial begin
        reset = 1'b0; Cond = 4'b1110; ALUFlags = 4'b1111; FlagW = 2'b11;
        PCS = 1'b1; NextPC = 1'b0; RegW = 1'b1; MemW = 1'b1;
        #2;
        // Reset held: flag writes and conditions must be ignored
        for (int i = 0; i < 3; i++) begin
            step();
            chk4("rst_flags", flags_a, 4'b0000);
            chk1("rst_condexq", cond_ex_q_a, 1'b0);
            chk1("rst_regwrite", reg_write_a, 1'b0);
            chk1("rst_memwrite", mem_write_a, 1'b0);
            chk1("rst_pcwrite", pc_write_a, 1'b0);
        end
        chk4("rst_flags_param", flags_b, 4'b0101);
        NextPC = 1'b1; #1;
        chk1("rst_pcwrite_nextpc", pc_write_a, 1'b1);
        $display("reset hold: flags=%b condexq=%b", flags_a, cond_ex_q_a);

        reset = 1'b1; NextPC = 1'b0; FlagW = 2'b00; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
        step();

        // Flag split
        Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b1111;
        step();
        chk4("split_nz", flags_a, 4'b1100);
        FlagW = 2'b01;
        step();
        chk4("split_cv", flags_a, 4'b1111);
        $display("flag split: flags=%b", flags_a);

        // Condition fail
        load_flags(4'b0000);
        Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b0100;
        RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; NextPC = 1'b0;
        step();
        chk4("fail_flags", flags_a, 4'b0000);
        chk1("fail_condexq", cond_ex_q_a, 1'b0);
        chk1("fail_regwrite", reg_write_a, 1'b0);
        chk1("fail_memwrite", mem_write_a, 1'b0);
        chk1("fail_pcwrite", pc_write_a, 1'b0);
        NextPC = 1'b1; #1;
        chk1("fail_pcwrite_nextpc", pc_write_a, 1'b1);
        $display("cond fail: flags=%b condexq=%b pcwrite=%b", flags_a, cond_ex_q_a, pc_write_a);
        NextPC = 1'b0; FlagW = 2'b00; RegW = 1'b0; MemW = 1'b0; PCS = 1'b0;

        // Condition pass latency
        load_flags(4'b0100);
        Cond = 4'b0001;
        step();
        chk1("lat_ne_fail", cond_ex_q_a, 1'b0);
        Cond = 4'b0000; RegW = 1'b1; PCS = 1'b1; #1;
        chk1("lat_before_edge", cond_ex_q_a, 1'b0);
        chk1("lat_regwrite_before", reg_write_a, 1'b0);
        step();
        chk1("lat_after_edge", cond_ex_q_a, 1'b1);
        chk1("lat_regwrite", reg_write_a, 1'b1);
        chk1("lat_memwrite", mem_write_a, 1'b0);
        chk1("lat_pcwrite", pc_write_a, 1'b1);
        $display("pass latency: condexq=%b regwrite=%b", cond_ex_q_a, reg_write_a);
        RegW = 1'b0; PCS = 1'b0;

        // Same-cycle hazard
        load_flags(4'b0000);
        Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b0100;
        step();
        chk4("hazard_suppressed", flags_a, 4'b0000);
        Cond = 4'b1110;
        step();
        chk4("hazard_al_update", flags_a, 4'b0100);
        Cond = 4'b0000; FlagW = 2'b00;
        step();
        chk1("hazard_next_eq", cond_ex_q_a, 1'b1);
        $display("hazard: flags=%b condexq=%b", flags_a, cond_ex_q_a);

        // Asynchronous reset between edges, then release
        load_flags(4'b1010);
        chk4("async_pre", flags_a, 4'b1010);
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0110;
        #2 reset = 1'b0;
        #1;
        chk4("async_flags", flags_a, 4'b0000);
        chk1("async_condexq", cond_ex_q_a, 1'b0);
        chk4("async_flags_param", flags_b, 4'b0101);
        reset = 1'b1;
        step();
        chk4("release_first_edge", flags_a, 4'b0110);
        chk1("release_condexq", cond_ex_q_a, 1'b1);
        $display("async reset: flags=%b condexq=%b", flags_a, cond_ex_q_a);

        // Full sweep of Cond x Flags on both NV_EXECUTES settings
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                load_flags(4'(f));
                Cond = 4'(c);
                step();
                chk1($sformatf("sweep_a c=%0d f=%0d", c, f), cond_ex_q_a, model(4'(c), 4'(f), 1'b1));
                chk1($sformatf("sweep_b c=%0d f=%0d", c, f), cond_ex_q_b, model(4'(c), 4'(f), 1'b0));
            end
            $display("sweep flags=%b done", 4'(f));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 SHALL have parameter RESET_FLAGS, default 4'b0000, NZCV value loaded into the flag register on reset.
REQ-002 SHALL have parameter NV_EXECUTES, default 1, CondEx value produced for Cond=4'b1111.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset (0 = asserted), acting on all state without waiting for clk.
REQ-005 SHALL have port Cond  input  4  condition field of the current instruction (Instr[31:28]).
REQ-006 SHALL have port ALUFlags  input  4  ALU result flags {N,Z,C,V}.
REQ-007 SHALL have port FlagW  input  2  flag-write request from the decoder: bit1 = N,Z; bit0 = C,V.
REQ-008 SHALL have ports PCS, NextPC, RegW, MemW  input  1 each  unconditioned decoder/FSM write requests.
REQ-009 SHALL have port PCWrite  output  1  gated PC write enable.
REQ-010 SHALL have ports RegWrite, MemWrite  output  1 each  gated register-file and memory write enables.
REQ-011 SHALL have port Flags  output  4  current registered {N,Z,C,V}.
REQ-012 SHALL have port CondExQ  output  1  registered condition-pass bit.

Function
REQ-013 SHALL compute CondEx combinationally from Cond and the registered Flags (not ALUFlags): EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 NV_EXECUTES.
REQ-014 SHALL form FlagWrite[1:0] = FlagW & {2{CondEx}}, using the undelayed CondEx.
REQ-015 SHALL load Flags[3:2] from ALUFlags[3:2] on a rising edge when FlagWrite[1]=1, else hold.
REQ-016 SHALL load Flags[1:0] from ALUFlags[1:0] on a rising edge when FlagWrite[0]=1, else hold; the two halves update independently.
REQ-017 SHALL register CondEx into CondExQ on every rising edge (one-cycle latency, no enable).
REQ-018 SHALL drive RegWrite = RegW & CondExQ and MemWrite = MemW & CondExQ, combinationally.
REQ-019 SHALL drive PCWrite = NextPC | (PCS & CondExQ); NextPC is never suppressed by a failed condition.
REQ-020 SHALL, when FlagWrite and a flag-dependent Cond occur in the same cycle, evaluate CondEx on the pre-update Flags; new flags are visible to CondEx the next cycle.
REQ-021 SHALL have no internal FSM; sequencing is owned by the main FSM, and this block holds exactly 5 state bits (Flags, CondExQ).
REQ-022 SHALL produce no X on any output when inputs are known, including Cond=1111.

Reset
REQ-023 SHALL, while reset=0, force Flags=RESET_FLAGS and CondExQ=0 asynchronously.
REQ-024 SHALL therefore hold RegWrite=0, MemWrite=0 and PCWrite=NextPC during reset.
REQ-025 SHALL, on reset assertion mid-instruction, discard any pending flag update; after release (reset 0->1) the first edge behaves as REQ-013..REQ-017 with the reset flag values.

Verification
REQ-026 Reset: hold reset=0, toggle FlagW=11, ALUFlags=1111 -> Flags=0000, CondExQ=0, RegWrite=MemWrite=0 throughout.
REQ-027 Flag split: Flags=0000, Cond=1110, FlagW=10, ALUFlags=1111, one edge -> Flags=1100; then FlagW=01 -> Flags=1111.
REQ-028 Cond fail: Flags=0000 (Z=0), Cond=0000 (EQ), FlagW=11, ALUFlags=0100, RegW=MemW=PCS=1 -> Flags unchanged 0000, next cycle CondExQ=0, RegWrite=MemWrite=PCWrite=0; NextPC=1 -> PCWrite=1.
REQ-029 Cond pass latency: Flags=0100, Cond=0000 -> CondExQ rises one edge later; RegW=1 then -> RegWrite=1.
REQ-030 Sweep: all 16 Cond x 16 Flags -> CondExQ matches REQ-013 table one cycle later, including Cond=1111 with NV_EXECUTES=1 and 0.
REQ-031 Same-cycle hazard: Flags=0000, Cond=0000, FlagW=11, ALUFlags=0100 -> CondEx=0 so Flags stay 0000 (update suppressed by own failed condition); with Cond=1110 -> Flags=0100, next cycle Cond=0000 gives CondEx=1.
